// File: rtl/decade_rr_arbiter_pkg.sv
// Shared definitions for the decade round-robin arbiter: FSM encoding,
// pointer width and small slot-vector helpers.
package decade_rr_arbiter_pkg;

  localparam int PTR_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  // Out-of-range slot indices read as 0 because the vector is zero-extended to 16 bits.
  function automatic logic slot_bit(input logic [15:0] vec, input logic [PTR_W-1:0] idx);
    return vec[idx];
  endfunction

  function automatic logic [15:0] slot_onehot(input logic [PTR_W-1:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/decade_ptr.sv
// Mod-N scan pointer with step enable and a registered wrap pulse on the
// N-1 -> 0 step; an illegal count (>= N) is forced back to 0.
module decade_ptr
  import decade_rr_arbiter_pkg::*;
#(
  parameter int N = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [PTR_W-1:0] count,
  output logic             wrap
);

  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] LIMIT = PTR_W'(N);

  logic [PTR_W-1:0] count_r;
  logic             wrap_r;

  // Pointer register and wrap pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {PTR_W{1'b0}};
      wrap_r  <= 1'b0;
    end else if (count_r >= LIMIT) begin
      count_r <= {PTR_W{1'b0}};
      wrap_r  <= 1'b0;
    end else if (step) begin
      if (count_r == LAST) begin
        count_r <= {PTR_W{1'b0}};
        wrap_r  <= 1'b1;
      end else begin
        count_r <= count_r + PTR_W'(1);
        wrap_r  <= 1'b0;
      end
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;

endmodule

// File: rtl/decade_rr_arbiter.sv
// Round-robin time-slot arbiter: scan pointer stops on a requesting slot,
// grants it one-hot for at most MAX_HOLD cycles, then idles one cycle.
module decade_rr_arbiter
  import decade_rr_arbiter_pkg::*;
#(
  parameter int N_REQ    = 10,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inhibit,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_vld,
  output logic [3:0]       grant_idx,
  output logic [3:0]       ptr,
  output logic             wrap,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_t        state_r, state_nx_s;
  logic [N_REQ-1:0]  grant_r, grant_nx_s;
  logic              vld_r;
  logic [PTR_W-1:0]  idx_r, idx_nx_s;
  logic [HOLD_W-1:0] hold_r, hold_nx_s;
  logic              timeout_r, timeout_nx_s;
  logic              step_s;
  logic [PTR_W-1:0]  ptr_s;
  logic              wrap_s;
  logic              req_at_ptr_s;
  logic              req_g_s;
  logic              done_g_s;
  logic              at_max_s;

  decade_ptr #(.N(N_REQ)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .step  (step_s),
    .count (ptr_s),
    .wrap  (wrap_s)
  );

  assign req_at_ptr_s = slot_bit(16'(req), ptr_s);
  assign req_g_s      = slot_bit(16'(req), idx_r);
  assign done_g_s     = slot_bit(16'(done), idx_r);
  assign at_max_s     = (hold_r == HOLD_MAX);

  // Next-state, grant decode, hold counter and pointer-step decisions.
  always_comb begin
    state_nx_s   = state_r;
    grant_nx_s   = grant_r;
    idx_nx_s     = idx_r;
    hold_nx_s    = hold_r;
    timeout_nx_s = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (inhibit) begin
          state_nx_s = ST_SCAN;
        end else if (req_at_ptr_s) begin
          state_nx_s = ST_GRANT;
          grant_nx_s = N_REQ'(slot_onehot(ptr_s));
          idx_nx_s   = ptr_s;
          hold_nx_s  = HOLD_W'(1);
        end else begin
          step_s = 1'b1;
        end
      end
      ST_GRANT: begin
        if (done_g_s || !req_g_s || at_max_s) begin
          state_nx_s   = ST_GAP;
          grant_nx_s   = {N_REQ{1'b0}};
          timeout_nx_s = at_max_s && !done_g_s && req_g_s;
        end else if (at_max_s) begin
          hold_nx_s = hold_r;
        end else begin
          hold_nx_s = hold_r + HOLD_W'(1);
        end
      end
      ST_GAP: begin
        // Step past the served slot so it is re-scanned last.
        step_s     = 1'b1;
        state_nx_s = ST_SCAN;
      end
      default: begin
        state_nx_s = ST_SCAN;
        grant_nx_s = {N_REQ{1'b0}};
        hold_nx_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_SCAN;
      grant_r   <= {N_REQ{1'b0}};
      vld_r     <= 1'b0;
      idx_r     <= {PTR_W{1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      grant_r   <= grant_nx_s;
      vld_r     <= |grant_nx_s;
      idx_r     <= idx_nx_s;
      hold_r    <= hold_nx_s;
      timeout_r <= timeout_nx_s;
    end
  end

  assign grant     = grant_r;
  assign grant_vld = vld_r;
  assign grant_idx = idx_r;
  assign ptr       = ptr_s;
  assign wrap      = wrap_s;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_decade_rr_arbiter.sv
// Directed bench for decade_rr_arbiter with a cycle-level reference model
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_decade_rr_arbiter;

  localparam int N  = 10;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       inhibit;
  logic [9:0] req;
  logic [9:0] done;
  logic [9:0] grant;
  logic       grant_vld;
  logic [3:0] grant_idx;
  logic [3:0] ptr;
  logic       wrap;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  decade_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .inhibit   (inhibit),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .ptr       (ptr),
    .wrap      (wrap),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, for how long, and where the scan stands.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_ptr   = 0;
  bit         m_gap   = 1'b0;
  logic [9:0] e_grant = 10'd0;
  logic [3:0] e_idx   = 4'd0;
  bit         e_wrap  = 1'b0;
  bit         e_tmo   = 1'b0;

  task automatic advance();
    m_ptr = (m_ptr + 1) % N;
    e_wrap = (m_ptr == 0);
  endtask

  task automatic model_step();
    e_wrap = 1'b0;
    e_tmo  = 1'b0;
    if (rst) begin
      m_owner = -1; m_age = 0; m_ptr = 0; m_gap = 1'b0; e_idx = 4'd0;
    end else if (m_gap) begin
      m_gap = 1'b0;
      advance();
    end else if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner] || m_age == MH) begin
        e_tmo   = (m_age == MH) && !done[m_owner] && req[m_owner];
        m_owner = -1;
        m_gap   = 1'b1;
      end else begin
        m_age++;
      end
    end else if (!inhibit) begin
      if (req[m_ptr]) begin
        m_owner = m_ptr;
        m_age   = 1;
        e_idx   = 4'(m_ptr);
      end else begin
        advance();
      end
    end
    e_grant = (m_owner >= 0) ? (10'd1 << m_owner) : 10'd0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("m_grant", 32'(grant), 32'(e_grant));
      check("m_vld", 32'(grant_vld), 32'(e_grant != 10'd0));
      check("m_ptr", 32'(ptr), 32'(m_ptr));
      check("m_wrap", 32'(wrap), 32'(e_wrap));
      check("m_timeout", 32'(timeout), 32'(e_tmo));
      if (e_grant != 10'd0) check("m_idx", 32'(grant_idx), 32'(e_idx));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 10'd0; done = 10'd0; inhibit = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int bound, input string name);
    int t = 0;
    while (grant_vld !== 1'b1 && t < bound) begin
      step();
      t++;
    end
    check(name, 32'(grant_vld), 32'd1);
  endtask

  int order[5] = '{0, 3, 9, 0, 3};

  initial begin
    int wraps;
    int held;
    rst = 1'b1; req = 10'h3FF; done = 10'd0; inhibit = 1'b0;

    // 1: reset with every slot requesting
    for (int k = 0; k < 2; k++) begin
      step();
      check("t1_grant", 32'(grant), 32'd0);
      check("t1_ptr", 32'(ptr), 32'd0);
      check("t1_wrap", 32'(wrap), 32'd0);
      check("t1_timeout", 32'(timeout), 32'd0);
    end
    rst = 1'b0; req = 10'd0;

    // 2: free-running scan and single wrap
    wraps = 0;
    for (int k = 1; k <= 11; k++) begin
      step();
      check("t2_ptr", 32'(ptr), 32'(k % 10));
      check("t2_wrap", 32'(wrap), 32'(k == 10));
      if (wrap === 1'b1) wraps++;
    end
    check("t2_wrap_count", 32'(wraps), 32'd1);

    // 3: single grant on slot 3
    do_reset();
    req = 10'h008;
    repeat (3) step();
    check("t3_pre_grant", 32'(grant), 32'd0);
    check("t3_ptr3", 32'(ptr), 32'd3);
    step();
    check("t3_grant", 32'(grant), 32'h008);
    check("t3_idx", 32'(grant_idx), 32'd3);
    repeat (2) step();
    done = 10'h008;
    step();
    done = 10'd0; req = 10'd0;
    check("t3_gap_grant", 32'(grant), 32'd0);
    check("t3_gap_ptr", 32'(ptr), 32'd3);
    step();
    check("t3_ptr4", 32'(ptr), 32'd4);

    // 4: round-robin over slots 0, 3, 9
    do_reset();
    req = 10'h209;
    for (int g = 0; g < 5; g++) begin
      wait_grant(25, "t4_bound");
      check("t4_order", 32'(grant_idx), 32'(order[g]));
      done = grant;
      step();
      done = 10'd0;
      check("t4_gap", 32'(grant), 32'd0);
    end

    // 5: forced release after MAX_HOLD, then another slot goes first
    do_reset();
    req = 10'h020;
    wait_grant(20, "t5_bound");
    check("t5_idx5", 32'(grant_idx), 32'd5);
    req = 10'h024;
    held = 1;
    while (grant_vld === 1'b1 && held < 20) begin
      step();
      if (grant_vld === 1'b1) held++;
    end
    check("t5_held", 32'(held), 32'd8);
    check("t5_timeout", 32'(timeout), 32'd1);
    step();
    check("t5_timeout_end", 32'(timeout), 32'd0);
    wait_grant(20, "t5_bound2");
    check("t5_next_idx", 32'(grant_idx), 32'd2);

    // 6: inhibit, done at MAX_HOLD, reset mid-grant
    do_reset();
    repeat (2) step();
    check("t6_ptr2", 32'(ptr), 32'd2);
    inhibit = 1'b1; req = 10'h004;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_inh_grant", 32'(grant), 32'd0);
      check("t6_inh_ptr", 32'(ptr), 32'd2);
    end
    inhibit = 1'b0;
    step();
    check("t6_grant2", 32'(grant), 32'h004);
    repeat (7) step();
    check("t6_hold8", 32'(grant), 32'h004);
    done = 10'h004;
    step();
    done = 10'd0;
    check("t6_rel_grant", 32'(grant), 32'd0);
    check("t6_rel_timeout", 32'(timeout), 32'd0);
    wait_grant(25, "t6_bound");
    rst = 1'b1;
    step();
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_vld", 32'(grant_vld), 32'd0);
    check("t6_rst_ptr", 32'(ptr), 32'd0);
    rst = 1'b0; req = 10'd0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
